// File: rtl/seven_seg_scan_pkg.sv
// Shared seven-segment constants and helpers for display blocks.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
// No state; pure constants and functions.
package seven_seg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Digit positions: 0 is the rightmost digit.
    typedef enum logic [1:0] {
        DIG_R_ONES = 2'd0,
        DIG_R_TENS = 2'd1,
        DIG_L_ONES = 2'd2,
        DIG_L_TENS = 2'd3
    } digit_e;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/Bcd_To_Seg.sv
// BCD nibble to active-low seven-segment decoder; values above 9 show a dash.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module Bcd_To_Seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner showing two BCD pairs from a per-frame snapshot.
// Latency: an/seg/dp are registered, one cycle behind the scan index; frame_tick marks the load cycle.
// Backpressure: none; free-running scan. Optional LEADING_ZERO_BLANK_EN blanks zero tens digits.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] left_reading,
    input  logic [7:0] right_reading,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int DIV = CLK_FREQ / DIGIT_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          digit_end;
    logic          frame_load;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;

    // Decode of the nibble selected by the current scan index.
    Bcd_To_Seg u_dec (
        .bcd   (nibble),
        .seg_n (dec_seg)
    );

    // Prescaler, scan index and snapshot advance; snapshot reloads as the index wraps 3->0.
    always_comb begin
        digit_end  = (presc_q == PRESC_MAX);
        frame_load = digit_end && (idx_q == 2'd3);
        presc_d    = digit_end ? '0 : presc_q + PW'(1);
        idx_d      = digit_end ? idx_q + 2'd1 : idx_q;
        snap_d     = frame_load ? {left_reading, right_reading} : snap_q;
    end

    // Select the nibble for the current digit from the frozen snapshot.
    always_comb begin
        nibble = snap_q[3:0];
        case (digit_e'(idx_q))
            DIG_R_ONES: nibble = snap_q[3:0];
            DIG_R_TENS: nibble = snap_q[7:4];
            DIG_L_ONES: nibble = snap_q[11:8];
            DIG_L_TENS: nibble = snap_q[15:12];
            default:    nibble = snap_q[3:0];
        endcase
    end

    // Next display outputs; dp lights only on digit 2 to separate the two pairs.
    always_comb begin
        an_d  = anode_for(idx_q);
        seg_d = dec_seg;
        dp_d  = (idx_q != 2'd2);
`ifdef LEADING_ZERO_BLANK_EN
        // Tens digits with a zero nibble go dark while the anode keeps scanning.
        if (((idx_q == 2'd3) || (idx_q == 2'd1)) && (nibble == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // State and output registers; reset forces everything dark immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'h0000;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_load;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with CLK_FREQ=1000, DIGIT_HZ=250 (4 clocks per digit).
module tb_seven_seg_scan;

    logic       clk;
    logic       reset;
    logic [7:0] left_reading;
    logic [7:0] right_reading;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks;
    int errors;
    int ft_count;

    seven_seg_scan #(
        .CLK_FREQ (1000),
        .DIGIT_HZ (250)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .left_reading  (left_reading),
        .right_reading (right_reading),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .frame_tick    (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n posedges, ending on a negedge where outputs are stable.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        left_reading  = 8'h12;
        right_reading = 8'h34;

        // Reset held for 5 cycles.
        tick(5);
        chk("rst_an",  16'(an),         16'(4'b1111));
        chk("rst_seg", 16'(seg),        16'(7'b1111111));
        chk("rst_dp",  16'(dp),         16'(1'b1));
        chk("rst_ft",  16'(frame_tick), 16'(1'b0));
        reset = 1'b0;

        // e1: digit 0 shows '0' from the zero snapshot.
        tick(1);
        chk("e1_an",  16'(an),  16'(4'b1110));
        chk("e1_seg", 16'(seg), 16'(7'b1000000));
        chk("e1_dp",  16'(dp),  16'(1'b1));
        chk("e1_ft",  16'(frame_tick), 16'(1'b0));
        tick(4);
        chk("e5_an",  16'(an),  16'(4'b1101));
        chk("e5_seg", 16'(seg), 16'(7'b1000000));
        tick(4);
        chk("e9_an",  16'(an),  16'(4'b1011));
        chk("e9_dp",  16'(dp),  16'(1'b0));
        tick(4);
        chk("e13_an", 16'(an),  16'(4'b0111));
        chk("e13_dp", 16'(dp),  16'(1'b1));
        tick(2);
        chk("e15_ft", 16'(frame_tick), 16'(1'b1));
        tick(1);
        chk("e16_ft", 16'(frame_tick), 16'(1'b0));
        chk("e16_an", 16'(an),  16'(4'b0111));

        // Frame with snapshot 12/34: digits show 4,3,2,1.
        tick(1);
        chk("f2_d0_an",  16'(an),  16'(4'b1110));
        chk("f2_d0_seg", 16'(seg), 16'(7'b0011001));
        chk("f2_d0_dp",  16'(dp),  16'(1'b1));
        // Two clocks after the frame_tick the right input changes; frame must not tear.
        right_reading = 8'h56;
        tick(4);
        chk("f2_d1_an",  16'(an),  16'(4'b1101));
        chk("f2_d1_seg", 16'(seg), 16'(7'b0110000));
        tick(4);
        chk("f2_d2_an",  16'(an),  16'(4'b1011));
        chk("f2_d2_seg", 16'(seg), 16'(7'b0100100));
        chk("f2_d2_dp",  16'(dp),  16'(1'b0));
        tick(4);
        chk("f2_d3_an",  16'(an),  16'(4'b0111));
        chk("f2_d3_seg", 16'(seg), 16'(7'b1111001));
        tick(2);
        chk("f2_ft", 16'(frame_tick), 16'(1'b1));
        tick(2);
        chk("f3_d0_seg", 16'(seg), 16'(7'b0000010));
        tick(4);
        chk("f3_d1_seg", 16'(seg), 16'(7'b0010010));

        // One frame_tick pulse per 16 clocks; next frame loads right=0F.
        right_reading = 8'h0F;
        ft_count = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (frame_tick === 1'b1) ft_count++;
        end
        chk("ft_per_frame", 16'(ft_count), 16'd1);
        chk("0f_d1_an", 16'(an), 16'(4'b1101));
`ifdef LEADING_ZERO_BLANK_EN
        chk("0f_d1_seg", 16'(seg), 16'(7'b1111111));
`else
        chk("0f_d1_seg", 16'(seg), 16'(7'b1000000));
`endif
        tick(12);
        chk("0f_d0_an",  16'(an),  16'(4'b1110));
        chk("0f_d0_seg", 16'(seg), 16'(7'b0111111));

        // Leading-zero case: left=05, right=07.
        left_reading  = 8'h05;
        right_reading = 8'h07;
        tick(16);
        chk("lz_d0_seg", 16'(seg), 16'(7'b1111000));
        tick(4);
        chk("lz_d1_an", 16'(an), 16'(4'b1101));
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d1_seg", 16'(seg), 16'(7'b1111111));
`else
        chk("lz_d1_seg", 16'(seg), 16'(7'b1000000));
`endif
        tick(4);
        chk("lz_d2_seg", 16'(seg), 16'(7'b0010010));
        chk("lz_d2_dp",  16'(dp),  16'(1'b0));
        tick(4);
        chk("lz_d3_an", 16'(an), 16'(4'b0111));
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d3_seg", 16'(seg), 16'(7'b1111111));
`else
        chk("lz_d3_seg", 16'(seg), 16'(7'b1000000));
`endif

        // Asynchronous reset in the middle of digit 2.
        tick(13);
        chk("pre_ar_an", 16'(an), 16'(4'b1011));
        #2 reset = 1'b1;
        #1;
        chk("ar_an",  16'(an),         16'(4'b1111));
        chk("ar_seg", 16'(seg),        16'(7'b1111111));
        chk("ar_dp",  16'(dp),         16'(1'b1));
        chk("ar_ft",  16'(frame_tick), 16'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        chk("post_ar_an",  16'(an),  16'(4'b1110));
        chk("post_ar_seg", 16'(seg), 16'(7'b1000000));
        tick(4);
        chk("post_ar_d1_an", 16'(an), 16'(4'b1101));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter DIGIT_HZ, default 1000, per-digit scan rate in Hz; DIV = CLK_FREQ/DIGIT_HZ clocks per digit, DIV >= 2.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 left_reading  input  8  BCD pair {tens,ones} shown on digits 3,2.
REQ-006 right_reading  input  8  BCD pair {tens,ones} shown on digits 1,0.
REQ-007 an  output  4  digit anodes, active-low, one-hot-low when active.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 frame_tick  output  1  one-cycle pulse when the snapshot reloads.

Function
REQ-011 Prescaler counts 0..DIV-1, width $clog2(DIV), wraps to 0; digit index (2 bits) advances on the cycle prescaler == DIV-1.
REQ-012 Digit index sequence 0,1,2,3,0...; index 0 = rightmost digit = right_reading[3:0], 1 = right_reading[7:4], 2 = left_reading[3:0], 3 = left_reading[7:4].
REQ-013 A 16-bit snapshot {left_reading,right_reading} is loaded on the cycle the index wraps 3->0; inputs changing mid-frame never alter the displayed frame (no tearing).
REQ-014 frame_tick is high exactly on the snapshot-load cycle, low otherwise.
REQ-015 an, seg, dp are registered; they reflect the current index and snapshot with 1 cycle latency.
REQ-016 an drives exactly one bit low (bit = index) outside reset; never two active simultaneously.
REQ-017 BCD 0-9 decode to standard patterns (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000).
REQ-018 Nibble values 10-15 display a dash (seg = 7'b0111111).
REQ-019 dp is low only while index 2 is active (separator between pairs), high otherwise.
REQ-020 Inputs are treated as synchronous to clk; no input synchroniser.

Reset
REQ-021 While reset high: prescaler 0, index 0, snapshot 0, an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
REQ-022 First posedge after reset release: an = 4'b1110, seg shows '0' (snapshot zero) until the first wrap.
REQ-023 Reset asserted mid-frame returns all state to REQ-021 values immediately, without waiting for a clock edge.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, digit 3 is blanked (seg = 7'b1111111, an still scans) if its snapshot nibble is 0, and digit 1 likewise if its nibble is 0.
REQ-025 Without LEADING_ZERO_BLANK_EN every digit always displays its decoded nibble.

Structure
REQ-026 Segment pattern constants (digits 0-9, dash, blank) live in the shared seg-constants include, reused by other display blocks.
REQ-027 Combinational sub-module Bcd_To_Seg (4-bit in, 7-bit active-low out, dash for >9) performs decode; seven_seg_scan instantiates it once on the muxed nibble.

Verification (CLK_FREQ=1000, DIGIT_HZ=250 -> DIV=4, 16-clock frame)
REQ-028 Reset held 5 cycles, then released -> an=1111/seg=1111111/dp=1 during reset; an=1110, seg=1000000 next edge.
REQ-029 left=8'h12, right=8'h34 before first wrap -> after wrap, an sequence 1110,1101,1011,0111 every 4 clocks showing 4,3,2,1; dp=0 only with an=1011; frame_tick one pulse per 16 clocks.
REQ-030 right changed 8'h34->8'h56 two clocks after a frame_tick -> remainder of frame still shows 4,3; next frame shows 6,5.
REQ-031 right=8'h0F -> digit 0 shows dash 0111111, digit 1 shows 0.
REQ-032 LEADING_ZERO_BLANK_EN defined, left=8'h05, right=8'h07 -> digits 3 and 1 seg=1111111 with an still scanning; undefined -> both show 1000000.
REQ-033 reset pulsed asynchronously mid-digit-2 -> outputs reach reset values before next posedge; scan restarts at index 0.
